// File: rtl/fifo_frame_pkg.sv
// Shared types, header layout and width helpers for the FIFO frame reader.
package fifo_frame_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StPayload,
    StDrain
  } frame_state_e;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  // Header word: {magic[31:24], seq[23:16], len[15:0]}
  localparam int unsigned HDR_LEN_LSB   = 0;
  localparam int unsigned HDR_LEN_W     = 16;
  localparam int unsigned HDR_SEQ_LSB   = 16;
  localparam int unsigned HDR_SEQ_W     = 8;
  localparam int unsigned HDR_MAGIC_LSB = 24;

  function automatic int unsigned level_w(input int unsigned fifo_size);
    return $clog2(fifo_size) + 1;
  endfunction

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic [31:0] make_header(input logic [7:0]  seq,
                                              input logic [15:0] len);
    logic [31:0] hdr;
    hdr = '0;
    hdr[HDR_MAGIC_LSB +: 8]       = HDR_MAGIC;
    hdr[HDR_SEQ_LSB +: HDR_SEQ_W] = seq;
    hdr[HDR_LEN_LSB +: HDR_LEN_W] = len;
    return hdr;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-stage stream master output register. Loads a new beat (or a bubble)
// whenever the current one is empty or being accepted.
module stream_out_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  load_en,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready
);

  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  tlast_q;

  assign load_en = ~tvalid_q | m_tready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else if (load_en) begin
      tvalid_q <= in_valid;
      tlast_q  <= in_valid & in_last;
      // Data is left untouched on bubbles to avoid needless toggling.
      if (in_valid) tdata_q <= in_data;
    end
  end

  assign m_tdata  = tdata_q;
  assign m_tvalid = tvalid_q;
  assign m_tlast  = tlast_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// Pops samples from the FIFO head and emits framed packets (header + payload,
// tlast on the final word), flushing partial frames after an idle timeout.
module fifo_frame_reader
  import fifo_frame_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  int unsigned FIFO_SIZE   = 1024,
  parameter  int unsigned FRAME_LEN   = 256,
  parameter  int unsigned TIMEOUT_CYC = 100000,
  localparam int unsigned LEVEL_W     = level_w(FIFO_SIZE)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_enable,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_vld,
  input  logic [LEVEL_W-1:0]    fifo_level,
  output logic                  fifo_rd,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic                  busy,
  output logic                  err_underrun,
  output logic [15:0]           frame_cnt
);

  localparam int unsigned        TIMER_W     = cnt_w(TIMEOUT_CYC);
  localparam logic [LEVEL_W-1:0] FRAME_LEN_L = LEVEL_W'(FRAME_LEN);
  localparam logic [TIMER_W-1:0] TIMEOUT_L   = TIMER_W'(TIMEOUT_CYC);

  frame_state_e       state_q;
  logic [LEVEL_W-1:0] len_q;
  logic [LEVEL_W-1:0] cnt_q;
  logic [TIMER_W-1:0] timer_q;
  logic [7:0]         seq_q;
  logic [15:0]        frame_cnt_q;
  logic               err_q;

  logic                  load_en;
  logic                  level_nz;
  logic                  level_full;
  logic                  start;
  logic                  last_pop;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  assign level_nz   = fifo_level != '0;
  assign level_full = fifo_level >= FRAME_LEN_L;
  assign start      = (state_q == StIdle) & cfg_enable & level_nz &
                      (level_full | (timer_q == TIMEOUT_L));
  assign last_pop   = cnt_q == (len_q - LEVEL_W'(1));

  // Gated by rstn so no sample is lost while the frame is being aborted.
  assign fifo_rd = rstn & (state_q == StPayload) & load_en & fifo_vld & (cnt_q < len_q);

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    unique case (state_q)
      StHeader: begin
        out_valid = 1'b1;
        out_data  = DATA_WIDTH'(make_header(seq_q, 16'(len_q)));
      end
      StPayload: begin
        out_valid = fifo_rd;
        out_data  = fifo_data;
        out_last  = last_pop;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      seq_q       <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_q   <= level_full ? FRAME_LEN_L : fifo_level;
            timer_q <= '0;
            state_q <= StHeader;
          end else if (!level_nz) begin
            timer_q <= '0;
          end else if (cfg_enable && !level_full && timer_q != TIMEOUT_L) begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        StHeader: begin
          if (load_en) begin
            cnt_q   <= '0;
            state_q <= StPayload;
          end
        end
        StPayload: begin
          if (fifo_rd) begin
            cnt_q <= cnt_q + LEVEL_W'(1);
            if (last_pop) state_q <= StDrain;
          end else if (load_en && !fifo_vld) begin
            err_q <= 1'b1;
          end
        end
        StDrain: begin
          if (m_tvalid && m_tready && m_tlast) begin
            seq_q       <= seq_q + 8'd1;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  stream_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (out_valid),
    .in_data  (out_data),
    .in_last  (out_last),
    .load_en  (load_en),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready)
  );

  assign busy         = state_q != StIdle;
  assign err_underrun = err_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Scoreboard bench for fifo_frame_reader: a queue model chunks pushed words
// into expected frames; a monitor pops and compares every accepted beat.
module tb_fifo_frame_reader;

  localparam int unsigned DW    = 32;
  localparam int unsigned FSIZE = 16;
  localparam int unsigned FLEN  = 4;
  localparam int unsigned TMO   = 20;
  localparam int unsigned LW    = $clog2(FSIZE) + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cfg_enable = 1'b0;
  logic [DW-1:0] fifo_data;
  logic          fifo_vld;
  logic [LW-1:0] fifo_level;
  logic          fifo_rd;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b1;
  logic          busy;
  logic          err_underrun;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  fifo_frame_reader #(
    .DATA_WIDTH  (DW),
    .FIFO_SIZE   (FSIZE),
    .FRAME_LEN   (FLEN),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cfg_enable   (cfg_enable),
    .fifo_data    (fifo_data),
    .fifo_vld     (fifo_vld),
    .fifo_level   (fifo_level),
    .fifo_rd      (fifo_rd),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tlast      (m_tlast),
    .m_tready     (m_tready),
    .busy         (busy),
    .err_underrun (err_underrun),
    .frame_cnt    (frame_cnt)
  );

  // Upstream sample FIFO stand-in.
  logic [DW-1:0] fmem [FSIZE];
  int            frd = 0, fwr = 0, fcount = 0, npops = 0;
  logic          push_req = 1'b0, fifo_clr = 1'b0, force_empty = 1'b0;
  logic [DW-1:0] push_data = '0;

  assign fifo_data  = fmem[frd];
  assign fifo_vld   = (fcount != 0) && !force_empty;
  assign fifo_level = LW'(fcount);

  always @(posedge clk) begin
    if (fifo_clr) begin
      frd    <= 0;
      fwr    <= 0;
      fcount <= 0;
    end else begin
      if (fifo_rd && fifo_vld) begin
        frd   <= (frd + 1) % FSIZE;
        npops <= npops + 1;
      end
      if (push_req) begin
        fmem[fwr] <= push_data;
        fwr       <= (fwr + 1) % FSIZE;
      end
      fcount <= fcount + int'(push_req) - int'(fifo_rd && fifo_vld);
    end
  end

  // Reference model state.
  logic [32:0]   exp_q[$];
  logic [DW-1:0] model_q[$];
  logic [7:0]    seq_model = 8'd0;
  int            frames_model = 0;
  int            errors = 0, checks = 0, beats_seen = 0;
  logic          rand_ready = 1'b0;

  task automatic expect_chunk(input int len);
    logic [DW-1:0] w;
    exp_q.push_back({1'b0, 8'hA5, seq_model, 16'(len)});
    for (int i = 0; i < len; i++) begin
      w = model_q.pop_front();
      exp_q.push_back({(i == len - 1), w});
    end
    seq_model    = seq_model + 8'd1;
    frames_model = frames_model + 1;
  endtask

  // Frames take min(level, FRAME_LEN) words from the FIFO head, in order.
  task automatic expect_all();
    int n;
    while (model_q.size() > 0) begin
      n = (model_q.size() >= FLEN) ? FLEN : model_q.size();
      expect_chunk(n);
    end
  endtask

  // Monitor: scoreboard compare plus handshake-rule checks.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (prev_stall) begin
          checks++;
          if (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last) begin
            errors++;
            $display("FAIL stall_hold: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                     m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
          end
        end
        if (m_tvalid && !m_tready) begin
          checks++;
          if (fifo_rd) begin
            errors++;
            $display("FAIL pop_while_stalled: fifo_rd=1 required 0");
          end
        end
        if (!busy) begin
          checks++;
          if (fifo_rd) begin
            errors++;
            $display("FAIL pop_while_idle: fifo_rd=1 required 0");
          end
        end
        if (m_tvalid && m_tready) begin
          checks++;
          beats_seen++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat: got d=%h l=%b required no beat", m_tdata, m_tlast);
          end else begin
            e = exp_q.pop_front();
            if ({m_tlast, m_tdata} !== e) begin
              errors++;
              $display("FAIL beat: got d=%h l=%b required d=%h l=%b",
                       m_tdata, m_tlast, e[31:0], e[32]);
            end
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Sole driver of m_tready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    push_req  = 1'b1;
    push_data = d;
    model_q.push_back(d);
    tick();
    push_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || fcount != 0) && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL %s: timed out with %0d beats owed, level %0d, required 0 and 0",
               name, exp_q.size(), fcount);
    end
  endtask

  task automatic wait_beats(input int target, input string name);
    int n;
    n = 0;
    while (beats_seen < target && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (beats_seen < target) begin
      errors++;
      $display("FAIL %s: saw %0d beats required %0d", name, beats_seen, target);
    end
  endtask

  initial begin
    int p0, n, w, b0;
    tick();
    tick();
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_underrun, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    rstn = 1'b1;
    tick();

    // Full frame of 0x10..0x13.
    for (int i = 0; i < 4; i++) push_word(32'h10 + i);
    expect_all();
    p0 = npops;
    cfg_enable = 1'b1;
    wait_idle("basic_frame");
    check("basic_pops", npops - p0, 4);
    check("basic_frame_cnt", frame_cnt, 16'(frames_model));

    // Partial frame flushed by timeout: 20 idle cycles plus 2 cycles latency.
    cfg_enable = 1'b0;
    push_word($urandom);
    push_word($urandom);
    tick();
    expect_all();
    cfg_enable = 1'b1;
    n = 0;
    while (!m_tvalid && n < 100) begin
      tick();
      n++;
    end
    check("timeout_latency", n, TMO + 2);
    wait_idle("timeout_frame");
    check("timeout_frame_cnt", frame_cnt, 16'(frames_model));

    // Random fills with random backpressure.
    rand_ready = 1'b1;
    for (int r = 0; r < 24; r++) begin
      w = $urandom_range(1, FSIZE);
      cfg_enable = 1'b0;
      for (int i = 0; i < w; i++) push_word($urandom);
      expect_all();
      cfg_enable = 1'b1;
      wait_idle("random_round");
      check("random_frame_cnt", frame_cnt, 16'(frames_model));
    end
    rand_ready = 1'b0;
    tick();
    tick();
    check("no_underrun_yet", err_underrun, 0);

    // Enable dropped mid-frame: frame completes, nothing further starts.
    cfg_enable = 1'b0;
    for (int i = 0; i < 12; i++) push_word($urandom);
    expect_chunk(FLEN);
    b0 = beats_seen;
    cfg_enable = 1'b1;
    wait_beats(b0 + 1, "en_drop_header");
    cfg_enable = 1'b0;
    repeat (TMO * 3) tick();
    check("en_drop_busy", busy, 0);
    check("en_drop_level", fcount, 8);
    check("en_drop_owed", exp_q.size(), 0);
    check("en_drop_frame_cnt", frame_cnt, 16'(frames_model));
    cfg_enable = 1'b1;
    expect_all();
    wait_idle("en_drop_rest");
    check("en_drop_rest_cnt", frame_cnt, 16'(frames_model));

    // Underrun: FIFO looks empty for 3 cycles mid-payload.
    cfg_enable = 1'b0;
    for (int i = 0; i < 4; i++) push_word($urandom);
    expect_all();
    b0 = beats_seen;
    cfg_enable = 1'b1;
    wait_beats(b0 + 2, "underrun_start");
    force_empty = 1'b1;
    repeat (3) begin
      tick();
      check("underrun_bubble", m_tvalid, 0);
    end
    force_empty = 1'b0;
    check("underrun_err", err_underrun, 1);
    wait_idle("underrun_frame");
    check("underrun_sticky", err_underrun, 1);
    check("underrun_frame_cnt", frame_cnt, 16'(frames_model));

    // Reset in the cycle after the 2nd payload beat.
    cfg_enable = 1'b0;
    for (int i = 0; i < 4; i++) push_word($urandom);
    expect_all();
    b0 = beats_seen;
    cfg_enable = 1'b1;
    wait_beats(b0 + 3, "reset_start");
    rstn       = 1'b0;
    fifo_clr   = 1'b1;
    cfg_enable = 1'b0;
    exp_q.delete();
    tick();
    check("reset_tvalid", m_tvalid, 0);
    check("reset_tlast", m_tlast, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_cnt", frame_cnt, 0);
    check("reset_err", err_underrun, 0);
    rstn         = 1'b1;
    fifo_clr     = 1'b0;
    seq_model    = 8'd0;
    frames_model = 0;
    tick();
    for (int i = 0; i < 4; i++) push_word($urandom);
    expect_all();
    cfg_enable = 1'b1;
    wait_idle("post_reset_frame");
    check("post_reset_frame_cnt", frame_cnt, 16'(frames_model));

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_frame_reader.md
Name: fifo_frame_reader

Overview:
- Read-side consumer of the sample FIFO. Pops 32-bit phase samples from the FIFO head using a vld/rdy pop handshake.
- Packs the samples into framed packets: one header word, then N payload words, with last asserted on the final word.
- Drives a stream master interface with backpressure towards the host DMA/SW link.
- Flushes a partial frame after a timeout, so slow sample rates still reach SW.

Parameters:
- DATA_WIDTH, 32: sample/word width. Fixed at 32 because the header layout depends on it.
- FIFO_SIZE, 1024: depth of the upstream FIFO. Sets LEVEL_W = $clog2(FIFO_SIZE)+1.
- FRAME_LEN, 256: maximum payload words per frame, 1..FIFO_SIZE.
- TIMEOUT_CYC, 100000: idle cycles with 0 < level < FRAME_LEN before a partial frame is sent.

Ports:
- clk, input, 1: clock.
- rstn, input, 1: reset, synchronous, active-low.
- cfg_enable, input, 1: allows a new frame to start. Sampled in IDLE only.
- fifo_data, input, DATA_WIDTH: FIFO head word, valid combinationally.
- fifo_vld, input, 1: FIFO non-empty.
- fifo_level, input, LEVEL_W: current FIFO occupancy.
- fifo_rd, output, 1: pop strobe. The head is consumed on a cycle where fifo_rd & fifo_vld.
- m_tdata, output, DATA_WIDTH: stream data.
- m_tvalid, output, 1: stream valid.
- m_tlast, output, 1: final word of the frame.
- m_tready, input, 1: stream ready from the sink.
- busy, output, 1: FSM not in IDLE.
- err_underrun, output, 1: sticky; set if FIFO empty while payload words are still owed.
- frame_cnt, output, 16: frames completed, wraps at 2^16.

Behaviour:
- Reset values: all outputs 0, FSM=IDLE, seq=0, timer=0, frame_cnt=0, err_underrun=0. Reset mid-frame aborts the frame immediately; no tlast is issued.
- Output stage is a single register. load_en = ~m_tvalid | m_tready. m_tdata, m_tvalid and m_tlast update only when load_en=1.
- m_tdata and m_tlast are held stable while m_tvalid & ~m_tready.
- FSM IDLE:
  - Timer counts while cfg_enable & 0 < fifo_level < FRAME_LEN. It clears when fifo_level==0 or a frame starts, and saturates at TIMEOUT_CYC.
  - Start condition: cfg_enable & (fifo_level >= FRAME_LEN | timer == TIMEOUT_CYC).
  - On start, latch len = min(fifo_level, FRAME_LEN) into len_q, then go to HEADER.
- FSM HEADER:
  - When load_en: m_tdata = {8'hA5, seq[7:0], len_q[15:0]}, m_tvalid=1, m_tlast=0. Go to PAYLOAD with cnt=0.
- FSM PAYLOAD:
  - fifo_rd = load_en & fifo_vld & (cnt < len_q), combinational.
  - On fifo_rd: m_tdata=fifo_data, m_tvalid=1, cnt++. m_tlast = (cnt == len_q-1).
  - If load_en & ~fifo_vld: m_tvalid=0 (bubble) and err_underrun<=1. The frame continues when data returns.
  - After the last word is loaded, go to DRAIN.
- FSM DRAIN:
  - Wait for the m_tvalid & m_tready handshake with m_tlast=1.
  - Then seq++, frame_cnt++, go to IDLE.
  - A new start can be evaluated on the cycle after returning to IDLE.
- Latency: start to header m_tvalid is 2 cycles. With m_tready held high there is 1 word per cycle and no bubbles. Header plus N payload words are sent in N+1 consecutive beats.
- Pop ordering:
  - fifo_rd is never asserted in IDLE, HEADER or DRAIN.
  - At most len_q pops per frame.
  - A concurrent FIFO push does not change len_q.
- cfg_enable deasserted mid-frame: the current frame completes, then the FSM stays in IDLE.
- seq: 8 bits, wraps 255 to 0.
- len_q == FRAME_LEN when the FIFO is full. len_q is never 0, because start requires level > 0.

Decomposition:
- Package fifo_frame_pkg holds:
  - the FSM state enum (IDLE, HEADER, PAYLOAD, DRAIN);
  - HDR_MAGIC = 8'hA5;
  - the header field offsets;
  - LEVEL_W computation helpers.
- One sub-module, stream_out_reg: the load_en-gated output register for tdata/tvalid/tlast. Keeps the backpressure logic isolated and reusable for other stream masters.

Test Plan:
1. FRAME_LEN=4, push 4 words 0x10..0x13, enable, m_tready=1.
   - Beats: 0xA5000004, 0x10, 0x11, 0x12, 0x13.
   - tlast on 0x13 only; exactly 4 fifo_rd pulses; frame_cnt=1.
2. TIMEOUT_CYC=20, push 2 words, enable.
   - No output for 20 cycles, then 0xA5000002 + 2 words with tlast.
   - Second frame header carries seq=1 (0xA5010002).
3. Backpressure: m_tready toggles 1,0,0,1 during a FRAME_LEN=4 frame.
   - m_tdata stable while stalled; no fifo_rd while load_en=0.
   - Total output identical to scenario 1; no duplicated or dropped words.
4. Sink FIFO underrun: force fifo_vld=0 for 3 cycles mid-payload.
   - m_tvalid=0 bubble; err_underrun=1 sticky.
   - The frame resumes and completes with the correct length.
5. Reset: assert rstn=0 in the cycle after the 2nd payload beat.
   - Next cycle: m_tvalid=0, busy=0, frame_cnt=0, seq=0.
   - Next frame header is 0xA500xxxx.
6. Enable drop: cfg_enable=0 mid-frame.
   - Current frame finishes with tlast; no new header follows although the FIFO still holds ≥FRAME_LEN words.
